// File: rtl/shared_eval_arbiter_pkg.sv
// Shared constants for the shared a+b+c evaluation arbiter: default sizes,
// result width helper and grant-statistics counter width/saturation value.
package shared_eval_arbiter_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_LAT     = 2;
    localparam int DEF_ID_W    = 2;

    localparam int              STATS_W   = 16;
    localparam logic [STATS_W-1:0] STATS_SAT = '1;

    // Sum of three DATA_W operands never needs more than two extra bits.
    function automatic int res_w(input int data_w);
        return data_w + 2;
    endfunction

endpackage

// File: rtl/shared_eval_arbiter_rr_grant.sv
// Combinational round-robin select: first valid requester at or after rr_ptr,
// wrapping at NUM_REQ (non-power-of-2 NUM_REQ supported).
module rr_grant #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx
);

    always_comb begin
        logic found;
        int   j;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!found && req_valid[j]) begin
                found     = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/shared_eval_arbiter.sv
// Round-robin arbiter feeding one shared a+b+c unit through a LAT-deep pipeline.
// Optional per-requester saturating grant counters under SHARED_EVAL_STATS_EN.
module shared_eval_arbiter
    import shared_eval_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int LAT     = DEF_LAT,
    parameter int ID_W    = DEF_ID_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ*DATA_W-1:0] req_c,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W+1:0]         rsp_data
`ifdef SHARED_EVAL_STATS_EN
    ,
    input  logic                      stats_clr,
    output logic [NUM_REQ*STATS_W-1:0] grant_cnt
`endif
);

    localparam int RES_W = res_w(DATA_W);

    logic [NUM_REQ-1:0]          grant;
    logic [ID_W-1:0]             gnt_idx;
    logic [ID_W-1:0]             rr_ptr_q, rr_ptr_d;
    logic                        stall, accept;
    logic [DATA_W-1:0]           a_sel, b_sel, c_sel;
    logic [RES_W-1:0]            sum_d;
    logic [LAT-1:0]              vld_q;
    logic [LAT-1:0][ID_W-1:0]    id_q;
    logic [LAT-1:0][RES_W-1:0]   dat_q;

    rr_grant #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr_grant (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr_q),
        .grant     (grant),
        .grant_idx (gnt_idx)
    );

    // Holding the whole pipe on backpressure keeps the response stable and
    // means no new request can be taken.
    assign stall     = rsp_valid & ~rsp_ready;
    assign req_ready = (stall || rst) ? '0 : grant;
    assign accept    = |(req_valid & req_ready);

    assign a_sel = req_a[gnt_idx*DATA_W +: DATA_W];
    assign b_sel = req_b[gnt_idx*DATA_W +: DATA_W];
    assign c_sel = req_c[gnt_idx*DATA_W +: DATA_W];
    assign sum_d = RES_W'(a_sel) + RES_W'(b_sel) + RES_W'(c_sel);

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept)
            rr_ptr_d = (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= '0;
            vld_q    <= '0;
            id_q     <= '0;
            dat_q    <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            if (!stall) begin
                vld_q[0] <= accept;
                id_q[0]  <= gnt_idx;
                dat_q[0] <= sum_d;
                for (int s = 1; s < LAT; s++) begin
                    vld_q[s] <= vld_q[s-1];
                    id_q[s]  <= id_q[s-1];
                    dat_q[s] <= dat_q[s-1];
                end
            end
        end
    end

    assign rsp_valid = vld_q[LAT-1];
    assign rsp_id    = id_q[LAT-1];
    assign rsp_data  = dat_q[LAT-1];

`ifdef SHARED_EVAL_STATS_EN
    logic [NUM_REQ-1:0][STATS_W-1:0] cnt_q;

    // Clear takes priority over a same-cycle grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (stats_clr) begin
            cnt_q <= '0;
        end else if (accept && cnt_q[gnt_idx] != STATS_SAT) begin
            cnt_q[gnt_idx] <= cnt_q[gnt_idx] + 1'b1;
        end
    end

    assign grant_cnt = cnt_q;
`endif

endmodule
